// File: rtl/pwm_capture_if.sv
// pwm_capture_if: valid/ready word channel out of the PWM capture block.
//   data_out   [15:8] direction code, [7:0] speed code
//   data_valid data_out holds a word the consumer has not taken yet
//   data_rdy   consumer takes data_out on a cycle where data_valid is high
// master = the capture block (producer), slave = the consumer.
interface pwm_capture_if;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_rdy;

  modport master (output data_out, output data_valid, input data_rdy);
  modport slave  (input data_out, input data_valid, output data_rdy);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures the high-time of the speed and direction PWM inputs,
// converts each to an 8-bit code and offers the pair as one 16-bit word.
// Ports:
//   clk      single clock
//   rst      asynchronous, active-low reset
//   spd_in   speed PWM pin (asynchronous to clk)
//   dir_in   direction PWM pin (asynchronous to clk)
//   bus      word handshake (data_out / data_valid / data_rdy)
//   sig_lost at least one channel has seen no edge for TIMEOUT_TICKS
//   overrun  one-cycle pulse when a completed pair is overwritten
//
// Channel FSM (index 0 = speed, 1 = direction):
//   state   | meaning
//   IDLE    | not measuring; waits for a rising edge
//   HIGH    | pulse in progress; count = ticks high so far
//   LOW     | between pulses; count = ticks low so far
module pwm_capture #(
  parameter int CNT_W         = 16,
  parameter int MIN_TICKS     = 400,
  parameter int SHIFT         = 1,
  parameter int TIMEOUT_TICKS = 16000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spd_in,
  input  logic               dir_in,
  pwm_capture_if.master      bus,
  output logic               sig_lost,
  output logic               overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT_C   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CODE_MX = CNT_W'(255);

  logic [1:0]       w_pin;
  logic [1:0]       r_sync1, r_sync2, r_prev;
  logic [1:0]       r_warm;
  logic             w_armed;
  logic [1:0]       w_rise, w_fall, w_latch;
  state_t           r_state [2];
  logic [CNT_W-1:0] r_count [2];
  logic [CNT_W-1:0] r_width [2];
  logic [1:0]       r_new, r_lost;
  logic [7:0]       w_code [2];
  logic             w_load, w_ovr;
  logic             r_overrun;

  function automatic logic [7:0] f_code(input logic [CNT_W-1:0] width);
    logic [CNT_W-1:0] excess;
    excess = (width - MIN_C) >> SHIFT;
    if (width < MIN_C)        return 8'h00;
    else if (excess > CODE_MX) return 8'hFF;
    else                       return excess[7:0];
  endfunction

  assign w_pin = {dir_in, spd_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_armed) r_warm <= r_warm + 2'd1;
    end
  end

  // The edge pipe restarts from zeros after reset; a pin already high at
  // release would otherwise look like a fresh rising edge. Edges are ignored
  // until the pipe holds only post-reset samples.
  assign w_armed = (r_warm == 2'd3);
  assign w_rise  = r_sync2 & ~r_prev & {2{w_armed}};
  assign w_fall  = ~r_sync2 & r_prev & {2{w_armed}};

  always_comb begin
    w_latch = '0;
    for (int c = 0; c < 2; c++) begin
      w_latch[c] = (r_state[c] == ST_HIGH) && w_fall[c];
      w_code[c]  = f_code(r_width[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= ST_IDLE;
        r_count[c] <= '0;
        r_width[c] <= '0;
      end
      r_lost <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (r_state[c])
          ST_IDLE: begin
            r_count[c] <= '0;
            if (w_rise[c]) begin
              r_state[c] <= ST_HIGH;
              r_count[c] <= ONE_C;
            end
          end
          ST_HIGH: begin
            if (w_fall[c]) begin
              r_width[c] <= r_count[c];
              r_lost[c]  <= 1'b0;
              r_state[c] <= ST_LOW;
              r_count[c] <= ONE_C;
            end else if (r_count[c] == TO_C) begin
              r_lost[c]  <= 1'b1;
              r_state[c] <= ST_IDLE;
              r_count[c] <= '0;
            end else begin
              r_count[c] <= (r_count[c] == SAT_C) ? r_count[c] : r_count[c] + ONE_C;
            end
          end
          ST_LOW: begin
            if (w_rise[c]) begin
              r_state[c] <= ST_HIGH;
              r_count[c] <= ONE_C;
            end else if (r_count[c] == TO_C) begin
              r_lost[c]  <= 1'b1;
              r_state[c] <= ST_IDLE;
              r_count[c] <= '0;
            end else begin
              r_count[c] <= (r_count[c] == SAT_C) ? r_count[c] : r_count[c] + ONE_C;
            end
          end
          default: begin
            r_state[c] <= ST_IDLE;
            r_count[c] <= '0;
          end
        endcase
      end
    end
  end

  assign w_load = r_new[0] & r_new[1] & (~bus.data_valid | bus.data_rdy);
  assign w_ovr  = r_new[0] & r_new[1] & bus.data_valid & ~bus.data_rdy & (|w_latch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      r_new          <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun <= w_ovr;
      if (w_load) begin
        bus.data_out   <= {w_code[1], w_code[0]};
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_rdy) begin
        bus.data_valid <= 1'b0;
      end
      // A width latched in the load cycle belongs to the next pair.
      for (int c = 0; c < 2; c++) begin
        if (w_latch[c])  r_new[c] <= 1'b1;
        else if (w_load) r_new[c] <= 1'b0;
      end
    end
  end

  assign sig_lost = |r_lost;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int MIN_T   = 400;
  localparam int SHIFT   = 1;
  localparam int TIMEOUT = 16000;

  logic clk = 1'b0;
  logic rst;
  logic spd_in, dir_in;
  logic sig_lost, overrun;

  pwm_capture_if u_if ();

  pwm_capture #(.CNT_W(CNT_W), .MIN_TICKS(MIN_T), .SHIFT(SHIFT), .TIMEOUT_TICKS(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .spd_in   (spd_in),
    .dir_in   (dir_in),
    .bus      (u_if),
    .sig_lost (sig_lost),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pulses are measured directly on the pin samples (count of high samples
  // between a qualified rising and falling sample). A measurement or timeout
  // reaches the output stage two clocks after the sample that revealed it.
  function automatic int m_code(input int w);
    int v;
    if (w < MIN_T) return 0;
    v = (w - MIN_T) / (1 << SHIFT);
    return (v > 255) ? 255 : v;
  endfunction

  int          m_run [2];
  int          m_kedge [2];
  int          m_scyc;
  bit          m_prev [2], m_have [2], m_meas [2], m_act [2];
  bit          p0_latch [2], p1_latch [2], p0_lost [2], p1_lost [2];
  int          p0_w [2], p1_w [2];
  int          m_width [2];
  bit          m_new [2], m_lostf [2];
  logic [15:0] m_data;
  bit          m_valid, m_ovr;

  initial begin
    bit ld, p;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_scyc = 0;
        for (int c = 0; c < 2; c++) begin
          m_run[c] = 0; m_kedge[c] = 0; m_prev[c] = 0; m_have[c] = 0;
          m_meas[c] = 0; m_act[c] = 0; p0_latch[c] = 0; p1_latch[c] = 0;
          p0_lost[c] = 0; p1_lost[c] = 0; p0_w[c] = 0; p1_w[c] = 0;
          m_width[c] = 0; m_new[c] = 0; m_lostf[c] = 0;
        end
        m_data = '0; m_valid = 0; m_ovr = 0;
      end else begin
        m_scyc++;
        ld    = m_new[0] && m_new[1] && (!m_valid || u_if.data_rdy);
        m_ovr = m_new[0] && m_new[1] && m_valid && !u_if.data_rdy && (p1_latch[0] || p1_latch[1]);
        if (ld) begin
          m_data  = {8'(m_code(m_width[1])), 8'(m_code(m_width[0]))};
          m_valid = 1;
        end else if (m_valid && u_if.data_rdy) begin
          m_valid = 0;
        end
        for (int c = 0; c < 2; c++) begin
          if (p1_latch[c]) begin
            m_width[c] = p1_w[c]; m_new[c] = 1; m_lostf[c] = 0;
          end else if (ld) begin
            m_new[c] = 0;
          end
          if (p1_lost[c]) m_lostf[c] = 1;
          p1_latch[c] = p0_latch[c]; p1_w[c] = p0_w[c]; p1_lost[c] = p0_lost[c];
        end
        for (int c = 0; c < 2; c++) begin
          p = (c == 0) ? spd_in : dir_in;
          p0_latch[c] = 0; p0_lost[c] = 0;
          if (m_have[c] && p && !m_prev[c]) begin
            m_meas[c] = 1; m_act[c] = 1; m_run[c] = 1; m_kedge[c] = m_scyc;
          end else if (m_have[c] && !p && m_prev[c]) begin
            if (m_meas[c]) begin
              p0_latch[c] = 1; p0_w[c] = m_run[c]; m_meas[c] = 0; m_kedge[c] = m_scyc;
            end
          end else begin
            if (p && m_meas[c]) m_run[c]++;
            if (m_act[c] && (m_scyc - m_kedge[c] == TIMEOUT)) begin
              p0_lost[c] = 1; m_act[c] = 0; m_meas[c] = 0;
            end
          end
          m_prev[c] = p; m_have[c] = 1;
        end
      end
    end
  end

  // ---------------- compare + event log ----------------
  int          word_cnt = 0, ovr_cnt = 0;
  int          vrise_cyc = 0, lost_rise_cyc = 0, lost_fall_cyc = 0;
  logic [15:0] vword = '0;
  bit          pv = 0, pl = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      checks++;
      if (u_if.data_out !== m_data || u_if.data_valid !== m_valid ||
          sig_lost !== (m_lostf[0] | m_lostf[1]) || overrun !== m_ovr) begin
        errors++;
        $display("FAIL model cyc %0d: got data=%h valid=%b lost=%b ovr=%b, expected data=%h valid=%b lost=%b ovr=%b",
                 cyc, u_if.data_out, u_if.data_valid, sig_lost, overrun,
                 m_data, m_valid, m_lostf[0] | m_lostf[1], m_ovr);
      end
      if (u_if.data_valid && (!pv || u_if.data_rdy)) begin
        word_cnt++; vword = u_if.data_out; vrise_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
      if (sig_lost && !pl) lost_rise_cyc = cyc;
      if (!sig_lost && pl) lost_fall_cyc = cyc;
      pv = u_if.data_valid;
      pl = sig_lost;
    end
  end

  // ---------------- stimulus ----------------
  int fall_cyc = 0, dfall_cyc = 0;

  // One PWM period starting with both pins high; width >= per keeps a pin
  // high for the whole period, width 0 keeps it low. Called at a negedge.
  task automatic run_pwm(input int sw, input int dw, input int per);
    int mx;
    mx = (sw > dw) ? sw : dw;
    for (int t = 0; t < per; t++) begin
      spd_in = (t < sw);
      dir_in = (t < dw);
      if (t == mx && mx < per) fall_cyc = cyc;
      if (t == dw && dw > 0 && dw < per) dfall_cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int wc, oc, d1;
    rst = 1'b0; spd_in = 1'b0; dir_in = 1'b0; u_if.data_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      spd_in = 1'($urandom_range(0, 1));
      dir_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("reset_data", int'(u_if.data_out), 0);
    chk("reset_valid", int'(u_if.data_valid), 0);
    chk("reset_lost", int'(sig_lost), 0);
    chk("reset_overrun", int'(overrun), 0);
    spd_in = 1'b0; dir_in = 1'b0; rst = 1'b1;
    idle(5);

    // nominal: 600 -> 100, 500 -> 50
    u_if.data_rdy = 1'b1;
    run_pwm(600, 500, 8000);
    chk("nom_word", int'(vword), 'h3264);
    chk("nom_latency", vrise_cyc - fall_cyc, 4);
    run_pwm(600, 500, 8000);
    chk("nom_words", word_cnt, 2);

    // code boundaries
    run_pwm(300, 911, 1500);  chk("bnd_300_911", int'(vword), 'hFF00);
    run_pwm(400, 401, 1500);  chk("bnd_400_401", int'(vword), 'h0000);
    run_pwm(401, 402, 1500);  chk("bnd_401_402", int'(vword), 'h0100);
    run_pwm(910, 1000, 1500); chk("bnd_910_1000", int'(vword), 'hFFFF);
    run_pwm(908, 909, 1500);  chk("bnd_908_909", int'(vword), 'hFEFE);

    // backpressure: first pair loads, second fills, third and fourth overrun
    u_if.data_rdy = 1'b0;
    wc = word_cnt; oc = ovr_cnt;
    run_pwm(600, 600, 1500);
    run_pwm(700, 700, 1500);
    run_pwm(800, 800, 1500);
    run_pwm(900, 900, 1500);
    chk("bp_held_word", int'(u_if.data_out), 'h6464);
    chk("bp_held_valid", int'(u_if.data_valid), 1);
    chk("bp_words", word_cnt - wc, 1);
    chk("bp_overruns", ovr_cnt - oc, 2);
    u_if.data_rdy = 1'b1;
    @(posedge clk); #2;
    chk("bp_latest", int'(u_if.data_out), 'hFAFA);
    chk("bp_no_gap", int'(u_if.data_valid), 1);
    @(posedge clk); #2;
    chk("bp_drain", int'(u_if.data_valid), 0);
    @(negedge clk);

    // direction lost, then recovers
    run_pwm(600, 500, 1500);
    wc = word_cnt;
    for (int i = 0; i < 11; i++) run_pwm(600, 0, 1500);
    chk("loss_flag", int'(sig_lost), 1);
    chk("loss_time", lost_rise_cyc - dfall_cyc, TIMEOUT + 3);
    chk("loss_words", word_cnt - wc, 0);
    wc = word_cnt;
    run_pwm(600, 500, 1500);
    d1 = dfall_cyc;
    run_pwm(600, 500, 1500);
    chk("resume_clear", int'(sig_lost), 0);
    chk("resume_clear_time", lost_fall_cyc - d1, 3);
    chk("resume_words", word_cnt - wc, 2);
    chk("resume_word", int'(vword), 'h3264);

    // speed stuck high; first period still pairs the earlier speed width
    run_pwm(1500, 500, 1500);
    wc = word_cnt;
    for (int i = 0; i < 10; i++) run_pwm(1500, 500, 1500);
    chk("stuck_lost", int'(sig_lost), 1);
    chk("stuck_words", word_cnt - wc, 0);
    run_pwm(600, 500, 1500);
    run_pwm(600, 500, 1500);
    chk("stuck_recover", int'(sig_lost), 0);
    chk("stuck_recover_word", int'(vword), 'h3264);

    // reset mid-pulse with a word pending
    u_if.data_rdy = 1'b0;
    run_pwm(600, 500, 1500);
    chk("mid_pending", int'(u_if.data_valid), 1);
    spd_in = 1'b1; dir_in = 1'b1;
    idle(200);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(u_if.data_valid), 0);
    chk("mid_rst_data", int'(u_if.data_out), 0);
    idle(5);
    rst = 1'b1;
    idle(100);
    spd_in = 1'b0; dir_in = 1'b0;
    idle(300);
    chk("mid_no_partial", int'(u_if.data_valid), 0);
    u_if.data_rdy = 1'b1;
    wc = word_cnt;
    run_pwm(700, 700, 1500);
    chk("mid_words", word_cnt - wc, 1);
    chk("mid_word", int'(vword), 'h9696);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
